// File: rtl/switch_bank_pkg.sv
// switch_bank_pkg: mode and FSM encodings shared by the switch bank.
package switch_bank_pkg;
    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_A2B  = 2'b01;
    localparam logic [1:0] MODE_B2A  = 2'b10;
    localparam logic [1:0] MODE_RSVD = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_SHIFT = 2'b01;
    localparam logic [1:0] ST_BLANK = 2'b10;

    function automatic logic [1:0] eff_mode(input logic [1:0] m, input logic blank);
        return (blank || m == MODE_RSVD) ? MODE_OFF : m;
    endfunction
endpackage

// File: rtl/switch_cell.sv
// switch_cell: one bidirectional channel, a tristate pair steered by mode and blank.
module switch_cell
    import switch_bank_pkg::*;
(
    input  logic [1:0] mode,
    input  logic       blank,
    inout  wire        a,
    inout  wire        b
);
    logic [1:0] em;

    assign em = eff_mode(mode, blank);
    assign b  = (em == MODE_A2B) ? a : 1'bz;
    assign a  = (em == MODE_B2A) ? b : 1'bz;
endmodule

// File: rtl/switch_bank_cfg.sv
// switch_bank_cfg: NCH-channel bidirectional switch bank with serial shadow load
// and break-before-make atomic commit.
module switch_bank_cfg
    import switch_bank_pkg::*;
#(
    parameter int NCH      = 8,
    parameter int DEAD_CYC = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    inout  wire  [NCH-1:0]   port_a,
    inout  wire  [NCH-1:0]   port_b,
    input  logic [1:0]       cfg_din,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic             cfg_commit,
    output logic             cfg_busy,
    output logic             cfg_done,
    output logic             cfg_err,
    output logic [2*NCH-1:0] active_cfg
);
    localparam int CW = $clog2(NCH + 1);
    localparam int BW = $clog2(DEAD_CYC + 1);

    logic [1:0]       state, state_nx;
    logic [CW-1:0]    cnt, cnt_post, cnt_nx;
    logic [BW-1:0]    bcnt, bcnt_nx;
    logic [2*NCH-1:0] shadow;
    logic             beat, blank, err_nx, load;

    assign beat  = cfg_valid & cfg_ready;
    assign blank = (state == ST_BLANK);

    // A beat arriving with a commit is counted before the commit is judged.
    always_comb begin
        cnt_post = beat ? cnt + 1'b1 : cnt;
        state_nx = state;
        cnt_nx   = cnt_post;
        bcnt_nx  = bcnt;
        err_nx   = 1'b0;
        load     = 1'b0;
        if (blank) begin
            err_nx  = cfg_commit;
            bcnt_nx = bcnt - 1'b1;
            if (bcnt == BW'(1)) begin
                state_nx = ST_IDLE;
                cnt_nx   = '0;
                load     = 1'b1;
            end
        end else begin
            if (beat)
                state_nx = ST_SHIFT;
            if (cfg_commit) begin
                if (cnt_post == CW'(NCH)) begin
                    state_nx = ST_BLANK;
                    bcnt_nx  = BW'(DEAD_CYC);
                end else begin
                    err_nx = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            bcnt       <= '0;
            shadow     <= '0;
            active_cfg <= '0;
            cfg_ready  <= 1'b1;
            cfg_busy   <= 1'b0;
            cfg_done   <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            bcnt      <= bcnt_nx;
            cfg_ready <= (state_nx != ST_BLANK) && (cnt_nx != CW'(NCH));
            cfg_busy  <= (state_nx == ST_BLANK);
            cfg_done  <= (state_nx == ST_BLANK) && (bcnt_nx == BW'(1));
            cfg_err   <= err_nx;
            if (load)
                active_cfg <= shadow;
            // First beat lands in the top channel, last beat in channel 0.
            for (int i = 0; i < NCH; i++)
                if (beat && cnt == CW'(NCH - 1 - i))
                    shadow[2*i +: 2] <= cfg_din;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_cell
        switch_cell u_cell (
            .mode  (active_cfg[2*i +: 2]),
            .blank (blank),
            .a     (port_a[i]),
            .b     (port_b[i])
        );
    end
endmodule

// File: tb/tb_switch_bank_cfg.sv
// tb_switch_bank_cfg: table-driven check of the switch bank with NCH=4, DEAD_CYC=2.
module tb_switch_bank_cfg;
    localparam int NCH = 4;

    typedef struct {
        logic        v;
        logic [1:0]  d;
        logic        c;
        logic [3:0]  src;
        logic [15:0] exp;
    } vec_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [1:0]     cfg_din;
    logic           cfg_valid, cfg_commit;
    logic           cfg_ready, cfg_busy, cfg_done, cfg_err;
    logic [7:0]     active_cfg;
    wire  [NCH-1:0] port_a, port_b;
    logic [NCH-1:0] src, a_drv, b_drv;
    int             nvec = 0;
    int             nfail = 0;
    vec_t           tbl[$];

    always #5 clk = ~clk;

    // src[i]=1: bench drives side A of channel i, else side B.
    for (genvar g = 0; g < NCH; g++) begin : g_drv
        assign port_a[g] = src[g] ? a_drv[g] : 1'bz;
        assign port_b[g] = src[g] ? 1'bz : b_drv[g];
    end

    switch_bank_cfg #(.NCH(NCH), .DEAD_CYC(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .port_a     (port_a),
        .port_b     (port_b),
        .cfg_din    (cfg_din),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_commit (cfg_commit),
        .cfg_busy   (cfg_busy),
        .cfg_done   (cfg_done),
        .cfg_err    (cfg_err),
        .active_cfg (active_cfg)
    );

    function automatic vec_t mk(logic v, logic [1:0] d, logic c, logic [3:0] s,
                                logic [3:0] flags, logic [7:0] act, logic [3:0] pas);
        vec_t r;
        r.v = v; r.d = d; r.c = c; r.src = s;
        r.exp = {flags, act, pas};
        return r;
    endfunction

    // A channel "passes" when the driven value 1 shows up on the far side.
    function automatic logic [3:0] pas_now();
        logic [3:0] p;
        for (int i = 0; i < NCH; i++)
            p[i] = src[i] ? (port_b[i] === 1'b1) : (port_a[i] === 1'b1);
        return p;
    endfunction

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic cyc(logic v, logic [1:0] d, logic c);
        cfg_valid = v; cfg_din = d; cfg_commit = c;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0; cfg_commit = 1'b0; cfg_din = 2'b00;
    endtask

    initial begin
        logic bad;
        rst_n = 1'b0; cfg_valid = 1'b0; cfg_commit = 1'b0; cfg_din = 2'b00;
        src = 4'b1111; a_drv = '1; b_drv = '1;
        // flags = {ready, busy, done, err}
        tbl.push_back(mk(1, 2'b01, 0, 4'b1011, 4'b1000, 8'h00, 4'b0000));
        tbl.push_back(mk(1, 2'b10, 0, 4'b1011, 4'b1000, 8'h00, 4'b0000));
        tbl.push_back(mk(1, 2'b00, 0, 4'b1011, 4'b1000, 8'h00, 4'b0000));
        tbl.push_back(mk(1, 2'b01, 0, 4'b1011, 4'b0000, 8'h00, 4'b0000));
        tbl.push_back(mk(0, 2'b00, 1, 4'b1011, 4'b0100, 8'h00, 4'b0000));
        tbl.push_back(mk(0, 2'b00, 0, 4'b1011, 4'b0110, 8'h00, 4'b0000));
        tbl.push_back(mk(0, 2'b00, 0, 4'b1011, 4'b1000, 8'h61, 4'b1101));
        tbl.push_back(mk(1, 2'b10, 0, 4'b1011, 4'b1000, 8'h61, 4'b1101));
        tbl.push_back(mk(1, 2'b10, 0, 4'b1011, 4'b1000, 8'h61, 4'b1101));
        tbl.push_back(mk(0, 2'b00, 1, 4'b1011, 4'b1001, 8'h61, 4'b1101));
        tbl.push_back(mk(1, 2'b01, 0, 4'b1011, 4'b1000, 8'h61, 4'b1101));
        tbl.push_back(mk(1, 2'b00, 0, 4'b1011, 4'b0000, 8'h61, 4'b1101));
        tbl.push_back(mk(1, 2'b01, 0, 4'b1011, 4'b0000, 8'h61, 4'b1101));
        tbl.push_back(mk(0, 2'b00, 1, 4'b1011, 4'b0100, 8'h61, 4'b0000));
        tbl.push_back(mk(0, 2'b00, 1, 4'b0011, 4'b0111, 8'h61, 4'b0000));
        tbl.push_back(mk(0, 2'b00, 0, 4'b0011, 4'b1000, 8'ha4, 4'b1110));
        tbl.push_back(mk(0, 2'b00, 1, 4'b0011, 4'b1001, 8'ha4, 4'b1110));
        tbl.push_back(mk(1, 2'b10, 0, 4'b0011, 4'b1000, 8'ha4, 4'b1110));
        tbl.push_back(mk(1, 2'b10, 0, 4'b0011, 4'b1000, 8'ha4, 4'b1110));
        tbl.push_back(mk(1, 2'b01, 0, 4'b0011, 4'b1000, 8'ha4, 4'b1110));
        tbl.push_back(mk(1, 2'b00, 0, 4'b0011, 4'b0000, 8'ha4, 4'b1110));
        tbl.push_back(mk(0, 2'b00, 1, 4'b0011, 4'b0100, 8'ha4, 4'b0000));
        tbl.push_back(mk(0, 2'b00, 0, 4'b0011, 4'b0110, 8'ha4, 4'b0000));
        tbl.push_back(mk(0, 2'b00, 0, 4'b0011, 4'b1000, 8'ha4, 4'b1110));
        tbl.push_back(mk(1, 2'b11, 0, 4'b0011, 4'b1000, 8'ha4, 4'b1110));
        tbl.push_back(mk(1, 2'b01, 0, 4'b0011, 4'b1000, 8'ha4, 4'b1110));
        tbl.push_back(mk(1, 2'b10, 0, 4'b0011, 4'b1000, 8'ha4, 4'b1110));
        tbl.push_back(mk(1, 2'b11, 0, 4'b0011, 4'b0000, 8'ha4, 4'b1110));
        tbl.push_back(mk(0, 2'b00, 1, 4'b0011, 4'b0100, 8'ha4, 4'b0000));
        tbl.push_back(mk(0, 2'b00, 0, 4'b1101, 4'b0110, 8'ha4, 4'b0000));
        tbl.push_back(mk(0, 2'b00, 0, 4'b1101, 4'b1000, 8'hdb, 4'b0110));
        tbl.push_back(mk(1, 2'b01, 0, 4'b1101, 4'b1000, 8'hdb, 4'b0110));
        tbl.push_back(mk(1, 2'b01, 0, 4'b1101, 4'b1000, 8'hdb, 4'b0110));
        tbl.push_back(mk(1, 2'b01, 0, 4'b1101, 4'b1000, 8'hdb, 4'b0110));
        tbl.push_back(mk(1, 2'b01, 1, 4'b1101, 4'b0100, 8'hdb, 4'b0000));
        tbl.push_back(mk(0, 2'b00, 0, 4'b1111, 4'b0110, 8'hdb, 4'b0000));
        tbl.push_back(mk(0, 2'b00, 0, 4'b1111, 4'b1000, 8'h55, 4'b1111));

        #12;
        chk("reset_flags_act", {cfg_ready, cfg_busy, cfg_done, cfg_err, active_cfg}, {4'b1000, 8'h00});
        chk("reset_ports", pas_now(), 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            src = tbl[i].src;
            cyc(tbl[i].v, tbl[i].d, tbl[i].c);
            chk($sformatf("vec%0d", i), {cfg_ready, cfg_busy, cfg_done, cfg_err, active_cfg, pas_now()},
                tbl[i].exp);
        end

        // Reversal of ch0 from A2B to B2A while side A is held at 1.
        cyc(1, 2'b01, 0); cyc(1, 2'b01, 0); cyc(1, 2'b01, 0); cyc(1, 2'b10, 0);
        cyc(0, 2'b00, 1);
        bad = (port_b[0] === 1'b1) || (port_b[0] === 1'bx);
        chk("rev_blank_b0", {31'd0, bad}, 32'd0);
        chk("rev_blank_busy", {cfg_busy, pas_now()}, {1'b1, 4'b0000});
        src = 4'b1110;
        cyc(0, 2'b00, 0);
        chk("rev_done", {cfg_done, cfg_busy, active_cfg}, {2'b11, 8'h55});
        cyc(0, 2'b00, 0);
        chk("rev_active", {cfg_done, cfg_busy, active_cfg}, {2'b00, 8'h56});
        chk("rev_follow1", {port_a[0], pas_now()}, {1'b1, 4'b1111});
        b_drv[0] = 1'b0;
        #1;
        chk("rev_follow0", {31'd0, port_a[0]}, 32'd0);
        b_drv[0] = 1'b1;

        // Async reset in the middle of a blanking window.
        cyc(1, 2'b10, 0); cyc(1, 2'b10, 0); cyc(1, 2'b10, 0); cyc(1, 2'b10, 0);
        cyc(0, 2'b00, 1);
        chk("rst_pre_busy", {31'd0, cfg_busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_flags", {cfg_ready, cfg_busy, cfg_done, cfg_err, active_cfg}, {4'b1000, 8'h00});
        chk("rst_mid_ports", pas_now(), 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(0, 2'b00, 1);
        chk("rst_commit_err", {cfg_ready, cfg_busy, cfg_done, cfg_err, active_cfg}, {4'b1001, 8'h00});
        cyc(0, 2'b00, 0);
        chk("rst_err_pulse", {cfg_err, pas_now()}, {1'b0, 4'b0000});

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
